// File: rtl/skid_pkg.sv
// Shared types and constants for the two-entry skid buffer stage.
package skid_pkg;

  // Occupancy of the stage: nothing, main only, or main plus skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Maximum number of words the stage can hold at once.
  localparam int unsigned SKID_DEPTH = 2;

endpackage : skid_pkg

// File: rtl/register.sv
// Plain n-bit enabled register with synchronous active-high clear.
module register #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [n-1:0] d,
  output logic [n-1:0] q
);

  logic [n-1:0] q_q;
  logic [n-1:0] q_d;

  // Load new data only when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Storage flop; clear has priority over load.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : register

// File: rtl/skid_register.sv
// Two-entry elastic pipeline stage. in_ready is decoded purely from the
// registered state so the producer never sees a combinational path from
// out_ready; the skid entry absorbs the one word that may arrive in the
// cycle the consumer stalls.
module skid_register
  import skid_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data
);

  skid_state_t  state_q;
  skid_state_t  state_d;
  logic         in_fire;
  logic         out_fire;
  logic         main_load;
  logic         main_from_skid;
  logic         skid_load;
  logic [n-1:0] main_in;
  logic [n-1:0] main_q;
  logic [n-1:0] skid_q;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = (state_q != FULL) && reset;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign out_data  = main_q;

  // Next-state and load decode; flush empties the stage and suppresses all loads.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d   = BUSY;
            main_load = 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            state_d   = FULL;
            skid_load = 1'b1;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_d        = BUSY;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Main takes the skid word when draining from FULL, otherwise the producer word.
  always_comb begin
    main_in = in_data;
    if (main_from_skid) begin
      main_in = skid_q;
    end
  end

  // State register; reset dominates flush and normal transitions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  register #(.n(n)) u_main (
    .clk (clk),
    .rst (!reset),
    .en  (main_load),
    .d   (main_in),
    .q   (main_q)
  );

  register #(.n(n)) u_skid (
    .clk (clk),
    .rst (!reset),
    .en  (skid_load),
    .d   (in_data),
    .q   (skid_q)
  );

endmodule : skid_register

// File: doc/skid_register.md
# skid_register

Elastic pipeline stage: an n-bit, two-entry skid buffer that sits between a producer and the next datapath stage. It decouples the valid/ready handshake so that `in_ready` depends only on internal state, never combinationally on `out_ready`. Full throughput of one word per cycle is sustained, and a synchronous flush discards everything in flight. It is the standard stage inserted ahead of each plain pipeline register wherever backpressure is needed.

## Interface
- `n`, default 32: data width in bits.

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low. Sampled on the `clk` rising edge.
- `flush` input, 1 bit: synchronous discard of all held data, active-high.
- `in_valid` input, 1 bit: the producer presents `in_data`.
- `in_ready` output, 1 bit: the stage can accept a word this cycle.
- `in_data` input, n bits: producer data.
- `out_valid` output, 1 bit: `out_data` holds a valid word.
- `out_ready` input, 1 bit: the consumer takes `out_data` this cycle.
- `out_data` output, n bits: head word.

## Operation
- Handshake events:
  - Input fire (`in_fire`) = `in_valid & in_ready`.
  - Output fire (`out_fire`) = `out_valid & out_ready`.
- Storage: a main register that drives `out_data`, plus a skid register. Both are n bits.
- States:
  - EMPTY: 0 words held.
  - BUSY: 1 word held, in main.
  - FULL: 2 words held, main plus skid.
- Outputs are decoded from state:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL) and `reset` high.
- Transitions, evaluated only when `reset` is high and `flush` is low:
  - EMPTY, `in_fire` → BUSY. Main ← `in_data`.
  - BUSY, `in_fire` and no `out_fire` → FULL. Skid ← `in_data`.
  - BUSY, `out_fire` and no `in_fire` → EMPTY.
  - BUSY, both fire → BUSY. Main ← `in_data` (pass-through).
  - FULL, `out_fire` → BUSY. Main ← skid. No input is possible because `in_ready` is 0.
  - In every other case the state and registers hold.
- Priority: `reset` low, then `flush`, then the normal transitions.
- `flush` forces EMPTY next cycle. The output word and any word accepted in the same cycle are dropped; the producer sees the handshake complete.
- Data is never reordered, duplicated, or lost except by `flush` or `reset`.

## Timing
- Reset values: state EMPTY, main = 0, skid = 0, `out_valid` = 0, `out_data` = 0.
- `in_ready` is 0 while `reset` is asserted and 1 in the first cycle after release.
- Latency: a word accepted at edge k appears on `out_data` with `out_valid` = 1 immediately after edge k. That is 1 cycle from `in_fire` to observability.
- Throughput: 1 word per cycle while `out_ready` = 1.
- `in_ready` has no combinational path from `out_ready`. `out_data` and `out_valid` are register outputs.
- After FULL, `in_ready` returns to 1 in the cycle after the first `out_fire`.
- Reset mid-operation: held words are lost. Any `in_valid` in the reset cycle is not accepted.
- Flush in FULL: both words are dropped. `in_ready` = 1 in the next cycle.

## Structure
- Package `skid_pkg`:
  - `skid_state_t` enum {EMPTY, BUSY, FULL}, encoded in 2 bits.
  - Localparam `SKID_DEPTH` = 2.
- Sub-module: two instances of the team's `register` (n bits), one for main and one for skid.
  - Each instance's enable comes from the load decode.
  - Each instance's active-high reset is driven by the inverted `reset`.
- The state machine is a single always_ff with a next-state always_comb in the top module.

## Test plan
- Reset and first transfer: assert `reset` low for 2 cycles, then release with `in_valid` = 1, `in_data` = 0xA5A5A5A5, `out_ready` = 1.
  - During reset: `out_valid` = 0, `out_data` = 0, `in_ready` = 0.
  - Next cycle: `out_valid` = 1, `out_data` = 0xA5A5A5A5.
- Streaming: feed 1, 2, 3, … 10 with `out_ready` held at 1.
  - Consumer receives 1..10 in order, one per cycle.
  - `in_ready` never drops.
- Backpressure: `out_ready` = 0 while feeding 0x11, 0x22, 0x33.
  - 0x11 and 0x22 are accepted; the state reaches FULL.
  - `in_ready` = 0; 0x33 is held by the producer.
  - Raising `out_ready` yields 0x11, 0x22, 0x33 in order with no gaps.
- Flush: reach FULL holding 0x44 and 0x55, then pulse `flush` for 1 cycle.
  - Next cycle: `out_valid` = 0, `in_ready` = 1.
  - A following word 0x66 is the first word out.
- Mid-operation reset: from FULL, assert `reset` low for 1 cycle.
  - State is EMPTY, `out_data` = 0, and no stale word is ever emitted.
- Randomised `in_valid`/`out_ready` for 2000 cycles, checked against a FIFO scoreboard.
  - Output order matches input order exactly.
  - At most 2 words are ever outstanding.
